// File: rtl/sand_mem_arbiter_if.sv
// sand_mem_arbiter_if: requester, RAM command and status signals of the framebuffer arbiter.
// master is the requester/RAM side, slave is the arbiter.
interface sand_mem_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) ();
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_gnt;
    logic              disp_rvalid;
    logic [DATA_W-1:0] disp_rdata;
    logic              host_req;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic              sim_req;
    logic              sim_we;
    logic [ADDR_W-1:0] sim_addr;
    logic [DATA_W-1:0] sim_wdata;
    logic              sim_gnt;
    logic              sim_rvalid;
    logic [DATA_W-1:0] sim_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [CNT_W-1:0]  sim_wait_cnt;

    modport master (
        output disp_req, disp_addr, host_req, host_addr, host_wdata,
               sim_req, sim_we, sim_addr, sim_wdata, mem_rdata,
        input  disp_gnt, disp_rvalid, disp_rdata, host_gnt, sim_gnt, sim_rvalid, sim_rdata,
               mem_addr, mem_we, mem_wdata, sim_wait_cnt
    );

    modport slave (
        input  disp_req, disp_addr, host_req, host_addr, host_wdata,
               sim_req, sim_we, sim_addr, sim_wdata, mem_rdata,
        output disp_gnt, disp_rvalid, disp_rdata, host_gnt, sim_gnt, sim_rvalid, sim_rdata,
               mem_addr, mem_we, mem_wdata, sim_wait_cnt
    );
endinterface

// File: rtl/sand_mem_arbiter.sv
// sand_mem_arbiter: shares the single-port cell framebuffer RAM between display, host and sim.
// Display has absolute priority; host and sim alternate round-robin over the remaining slots.
module sand_mem_arbiter #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input logic clk,
    input logic reset,
    sand_mem_arbiter_if.slave bus
);
    localparam logic RR_HOST = 1'b0;
    localparam logic RR_SIM  = 1'b1;

    logic              rr;
    logic              tag_v;
    logic              tag_sim;
    logic              any_gnt;
    logic              rd_gnt;
    logic              wr_gnt;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    assign bus.disp_gnt = !reset && bus.disp_req;
    assign bus.host_gnt = !reset && !bus.disp_req && bus.host_req && (!bus.sim_req || rr == RR_HOST);
    assign bus.sim_gnt  = !reset && !bus.disp_req && bus.sim_req && (!bus.host_req || rr == RR_SIM);
    assign any_gnt   = bus.disp_gnt || bus.host_gnt || bus.sim_gnt;
    assign rd_gnt    = bus.disp_gnt || (bus.sim_gnt && !bus.sim_we);
    assign wr_gnt    = bus.host_gnt || (bus.sim_gnt && bus.sim_we);
    assign cmd_addr  = bus.disp_gnt ? bus.disp_addr : bus.host_gnt ? bus.host_addr : bus.sim_addr;
    assign cmd_wdata = bus.host_gnt ? bus.host_wdata : bus.sim_wdata;

    // The read tag travels alongside the RAM command; the rvalid/rdata registers form its second stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.mem_addr     <= '0;
            bus.mem_we       <= 1'b0;
            bus.mem_wdata    <= '0;
            bus.disp_rvalid  <= 1'b0;
            bus.disp_rdata   <= '0;
            bus.sim_rvalid   <= 1'b0;
            bus.sim_rdata    <= '0;
            bus.sim_wait_cnt <= '0;
            rr               <= RR_HOST;
            tag_v            <= 1'b0;
            tag_sim          <= 1'b0;
        end else begin
            bus.mem_we       <= wr_gnt;
            bus.mem_addr     <= any_gnt ? cmd_addr : bus.mem_addr;
            bus.mem_wdata    <= wr_gnt ? cmd_wdata : bus.mem_wdata;
            rr               <= bus.host_gnt ? RR_SIM : bus.sim_gnt ? RR_HOST : rr;
            tag_v            <= rd_gnt;
            tag_sim          <= bus.sim_gnt;
            bus.disp_rvalid  <= tag_v && !tag_sim;
            bus.disp_rdata   <= (tag_v && !tag_sim) ? bus.mem_rdata : bus.disp_rdata;
            bus.sim_rvalid   <= tag_v && tag_sim;
            bus.sim_rdata    <= (tag_v && tag_sim) ? bus.mem_rdata : bus.sim_rdata;
            bus.sim_wait_cnt <= (bus.sim_req && !bus.sim_gnt && bus.sim_wait_cnt != {CNT_W{1'b1}}) ?
                                bus.sim_wait_cnt + 1'b1 : bus.sim_wait_cnt;
        end
    end
endmodule

// File: tb/tb_sand_mem_arbiter.sv
// tb_sand_mem_arbiter: grant vector table, hand-written corner sequences and a read-data scoreboard.
// The RAM model returns data for the registered address within the same cycle.
module tb_sand_mem_arbiter;
    localparam int ADDR_W = 15;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;

    typedef struct packed {
        logic d, h, s, we, gd, gh, gs;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pl_en = 1'b0;
    logic [ADDR_W-1:0] pl_addr = '0;
    logic [DATA_W-1:0] pl_data = '0;
    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1] = '{default: 8'h00};
    logic [DATA_W-1:0] shadow [0:(1<<ADDR_W)-1] = '{default: 8'h00};
    logic [DATA_W-1:0] disp_q[$];
    logic [DATA_W-1:0] sim_q[$];
    int tests = 0;
    int fails = 0;
    vec_t tbl [15];

    sand_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    sand_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    assign bus.mem_rdata = ram[bus.mem_addr];

    always @(posedge clk) begin
        if (pl_en) ram[pl_addr] <= pl_data;
        else if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference memory follows grant order; expected read data is captured at grant time.
    always @(negedge clk) begin
        if (reset) begin
            disp_q.delete();
            sim_q.delete();
        end else begin
            chk("one_gnt", 32'($countones({bus.disp_gnt, bus.host_gnt, bus.sim_gnt}) <= 1), 32'd1);
            if (bus.disp_rvalid) begin
                if (disp_q.size() == 0) chk("disp_rvalid_unexpected", 32'd1, 32'd0);
                else chk("disp_rdata", 32'(bus.disp_rdata), 32'(disp_q.pop_front()));
            end
            if (bus.sim_rvalid) begin
                if (sim_q.size() == 0) chk("sim_rvalid_unexpected", 32'd1, 32'd0);
                else chk("sim_rdata", 32'(bus.sim_rdata), 32'(sim_q.pop_front()));
            end
            if (pl_en) shadow[pl_addr] <= pl_data;
            if (bus.host_gnt) shadow[bus.host_addr] <= bus.host_wdata;
            if (bus.sim_gnt && bus.sim_we) shadow[bus.sim_addr] <= bus.sim_wdata;
            if (bus.disp_gnt) disp_q.push_back(shadow[bus.disp_addr]);
            if (bus.sim_gnt && !bus.sim_we) sim_q.push_back(shadow[bus.sim_addr]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.disp_req = 1'b0;
        bus.host_req = 1'b0;
        bus.sim_req = 1'b0;
        bus.sim_we = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        pl_en = 1'b1;
        pl_addr = a;
        pl_data = d;
        tick();
        pl_en = 1'b0;
    endtask

    initial begin
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ed;
        bus.disp_addr = '0;
        bus.host_addr = '0;
        bus.host_wdata = '0;
        bus.sim_addr = '0;
        bus.sim_wdata = '0;
        idle();
        tick();
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_gnt", 32'({bus.disp_gnt, bus.host_gnt, bus.sim_gnt}), 32'd0);
        chk("rst_wait_cnt", 32'(bus.sim_wait_cnt), 32'd0);
        chk("rst_rvalid", 32'({bus.disp_rvalid, bus.sim_rvalid}), 32'd0);
        reset = 1'b0;

        // Single display read
        preload(15'h0123, 8'hA5);
        bus.disp_req = 1'b1;
        bus.disp_addr = 15'h0123;
        #1 chk("t1_disp_gnt", 32'(bus.disp_gnt), 32'd1);
        tick();
        bus.disp_req = 1'b0;
        chk("t1_mem_addr", 32'(bus.mem_addr), 32'h0123);
        chk("t1_mem_we", 32'(bus.mem_we), 32'd0);
        chk("t1_rvalid_c1", 32'(bus.disp_rvalid), 32'd0);
        tick();
        chk("t1_rvalid_c2", 32'(bus.disp_rvalid), 32'd1);
        chk("t1_rdata", 32'(bus.disp_rdata), 32'hA5);
        tick();
        chk("t1_rvalid_c3", 32'(bus.disp_rvalid), 32'd0);

        // Grant table: {disp, host, sim, sim_we, exp disp_gnt, exp host_gnt, exp sim_gnt}
        tbl[0]  = 7'b0111_010;
        tbl[1]  = 7'b0110_001;
        tbl[2]  = 7'b0111_010;
        tbl[3]  = 7'b0111_001;
        tbl[4]  = 7'b1110_100;
        tbl[5]  = 7'b0110_010;
        tbl[6]  = 7'b1010_100;
        tbl[7]  = 7'b0010_001;
        tbl[8]  = 7'b0011_001;
        tbl[9]  = 7'b0110_010;
        tbl[10] = 7'b0000_000;
        tbl[11] = 7'b0110_001;
        tbl[12] = 7'b0100_010;
        tbl[13] = 7'b0000_000;
        tbl[14] = 7'b1000_100;
        do_reset();
        for (int i = 0; i < 15; i++) begin
            bus.disp_req = tbl[i].d;
            bus.host_req = tbl[i].h;
            bus.sim_req = tbl[i].s;
            bus.sim_we = tbl[i].we;
            bus.host_addr = 15'(32'h100 + (i & 3));
            bus.sim_addr = 15'(32'h100 + ((i + 1) & 3));
            bus.disp_addr = 15'(32'h100 + ((i + 2) & 3));
            bus.host_wdata = 8'(32'h40 + i);
            bus.sim_wdata = 8'(32'h80 + i);
            #1;
            chk($sformatf("tbl%0d_gnt", i), 32'({bus.disp_gnt, bus.host_gnt, bus.sim_gnt}),
                32'({tbl[i].gd, tbl[i].gh, tbl[i].gs}));
            ea = tbl[i].gd ? bus.disp_addr : tbl[i].gh ? bus.host_addr : bus.sim_addr;
            ed = tbl[i].gh ? bus.host_wdata : bus.sim_wdata;
            tick();
            chk($sformatf("tbl%0d_mem_we", i), 32'(bus.mem_we), 32'(tbl[i].gh || (tbl[i].gs && tbl[i].we)));
            if (tbl[i].gd || tbl[i].gh || tbl[i].gs) chk($sformatf("tbl%0d_mem_addr", i), 32'(bus.mem_addr), 32'(ea));
            if (tbl[i].gh || (tbl[i].gs && tbl[i].we)) chk($sformatf("tbl%0d_mem_wdata", i), 32'(bus.mem_wdata), 32'(ed));
        end
        idle();
        tick();
        tick();

        // All three requesting: display starves host and sim
        do_reset();
        bus.disp_req = 1'b1;
        bus.host_req = 1'b1;
        bus.sim_req = 1'b1;
        bus.disp_addr = 15'h0100;
        for (int c = 0; c < 10; c++) begin
            #1 chk($sformatf("t3_gnt_c%0d", c), 32'({bus.disp_gnt, bus.host_gnt, bus.sim_gnt}), 32'b100);
            tick();
        end
        idle();
        chk("t3_wait_cnt", 32'(bus.sim_wait_cnt), 32'd10);
        tick();
        tick();

        // Back-to-back display reads
        for (int a = 0; a < 4; a++) preload(15'(a), 8'(a) ^ 8'hFF);
        for (int c = 0; c < 7; c++) begin
            bus.disp_req = (c < 4);
            bus.disp_addr = 15'(c);
            #1 chk($sformatf("t4_rvalid_c%0d", c), 32'(bus.disp_rvalid), 32'(c >= 2 && c <= 5));
            if (c >= 2 && c <= 5) chk($sformatf("t4_rdata_c%0d", c), 32'(bus.disp_rdata), 32'(8'(c - 2) ^ 8'hFF));
            tick();
        end
        idle();

        // Host write followed by sim read of the same cell
        preload(15'h0040, 8'h33);
        bus.host_req = 1'b1;
        bus.host_addr = 15'h0040;
        bus.host_wdata = 8'h07;
        #1 chk("t5_host_gnt", 32'(bus.host_gnt), 32'd1);
        tick();
        bus.host_req = 1'b0;
        bus.sim_req = 1'b1;
        bus.sim_we = 1'b0;
        bus.sim_addr = 15'h0040;
        #1 chk("t5_sim_gnt", 32'(bus.sim_gnt), 32'd1);
        tick();
        idle();
        chk("t5_rvalid_c2", 32'(bus.sim_rvalid), 32'd0);
        tick();
        chk("t5_rvalid_c3", 32'(bus.sim_rvalid), 32'd1);
        chk("t5_rdata", 32'(bus.sim_rdata), 32'h07);
        tick();

        // Reset while a sim read is in flight
        do_reset();
        bus.sim_req = 1'b1;
        bus.sim_addr = 15'h0040;
        #1 chk("t6_sim_gnt", 32'(bus.sim_gnt), 32'd1);
        tick();
        bus.disp_req = 1'b1;
        reset = 1'b1;
        #1;
        chk("t6_gnt_in_reset", 32'({bus.disp_gnt, bus.host_gnt, bus.sim_gnt}), 32'd0);
        chk("t6_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("t6_mem_we", 32'(bus.mem_we), 32'd0);
        chk("t6_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("t6_rdata", 32'({bus.disp_rdata, bus.sim_rdata}), 32'd0);
        chk("t6_rvalid", 32'({bus.disp_rvalid, bus.sim_rvalid}), 32'd0);
        idle();
        tick();
        tick();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("t6_no_rvalid_c%0d", c), 32'(bus.sim_rvalid), 32'd0);
            tick();
        end

        // Saturating starvation counter
        bus.disp_req = 1'b1;
        bus.disp_addr = 15'h0040;
        bus.sim_req = 1'b1;
        repeat (70000) tick();
        idle();
        chk("t6_wait_sat", 32'(bus.sim_wait_cnt), 32'hFFFF);
        tick();
        tick();
        tick();
        chk("disp_q_drained", 32'(disp_q.size()), 32'd0);
        chk("sim_q_drained", 32'(sim_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
